// File: rtl/pixel_dispatcher.sv
// Raster-order pixel dispatcher: walks a width x height frame and offers each
// pixel round-robin to N core ports over a valid/ready handshake.
module pixel_dispatcher #(
  parameter int unsigned MAX_CORES = 2,
  parameter int unsigned COORD_W   = 13
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [COORD_W-1:0]   image_width,
  input  logic [COORD_W-1:0]   image_height,
  input  logic [2:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] core_valid,
  output logic [COORD_W-1:0]   pix_x,
  output logic [COORD_W-1:0]   pix_y,
  output logic                 sof,
  output logic                 eol,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DONE
  } state_e;

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [2:0]         LAST_MAX = 3'(MAX_CORES - 1);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [COORD_W-1:0]   w_q, w_d;
  logic [COORD_W-1:0]   h_q, h_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           last_idx_q, last_idx_d;
  logic [MAX_CORES-1:0] core_valid_q, core_valid_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic xfer;
  logic last_x;
  logic last_y;

  function automatic logic [MAX_CORES-1:0] onehot(input logic [2:0] idx);
    logic [MAX_CORES-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      v[i] = (idx == 3'(i));
    end
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    core_valid_d = core_valid_q;
    sof_d        = sof_q;
    eol_d        = eol_q;
    frame_done_d = 1'b0;

    // Only the selected core can hold a valid bit, so this ignores the rest.
    xfer   = |(core_valid_q & core_ready);
    last_x = (x_q == w_q - ONE);
    last_y = (y_q == h_q - ONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (image_width != '0 && image_height != '0) begin
            w_d          = image_width;
            h_d          = image_height;
            last_idx_d   = (no_of_extra_cores > LAST_MAX) ? LAST_MAX : no_of_extra_cores;
            x_d          = '0;
            y_d          = '0;
            idx_d        = '0;
            core_valid_d = onehot(3'd0);
            sof_d        = 1'b1;
            eol_d        = (image_width == ONE);
            state_d      = S_DISPATCH;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end

      S_DISPATCH: begin
        if (xfer) begin
          if (last_x && last_y) begin
            x_d          = '0;
            y_d          = '0;
            idx_d        = '0;
            core_valid_d = '0;
            sof_d        = 1'b0;
            eol_d        = 1'b0;
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            x_d          = last_x ? '0 : x_q + ONE;
            y_d          = last_x ? y_q + ONE : y_q;
            idx_d        = (idx_q == last_idx_q) ? 3'd0 : idx_q + 3'd1;
            core_valid_d = onehot(idx_d);
            sof_d        = 1'b0;
            eol_d        = (x_d == w_q - ONE);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      core_valid_q <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      core_valid_q <= core_valid_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign core_valid = core_valid_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: raster-index reference model checked every cycle,
// plus directed scenarios with literal expectations on the transfer log.
module tb_pixel_dispatcher;

  localparam int MAXC = 2;
  localparam int CW   = 13;

  logic            aclk;
  logic            aresetn;
  logic            start;
  logic [CW-1:0]   image_width;
  logic [CW-1:0]   image_height;
  logic [2:0]      no_of_extra_cores;
  logic [MAXC-1:0] core_ready;
  logic [MAXC-1:0] core_valid;
  logic [CW-1:0]   pix_x;
  logic [CW-1:0]   pix_y;
  logic            sof;
  logic            eol;
  logic            busy;
  logic            frame_done;

  pixel_dispatcher #(.MAX_CORES(MAXC), .COORD_W(CW)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start             (start),
    .image_width       (image_width),
    .image_height      (image_height),
    .no_of_extra_cores (no_of_extra_cores),
    .core_ready        (core_ready),
    .core_valid        (core_valid),
    .pix_x             (pix_x),
    .pix_y             (pix_y),
    .sof               (sof),
    .eol               (eol),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame tracked as a linear raster index k.
  int m_w = 0, m_h = 0, m_n = 1, m_k = 0;
  bit m_act = 0, m_done = 0, m_fd = 0;

  always @(posedge aclk or negedge aresetn) begin
    int e;
    if (!aresetn) begin
      m_act = 0; m_done = 0; m_fd = 0; m_k = 0; m_w = 0; m_h = 0; m_n = 1;
    end else begin
      m_fd = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_act) begin
        if (core_ready[m_k % m_n]) begin
          m_k++;
          if (m_k == m_w * m_h) begin
            m_act = 0; m_done = 1; m_fd = 1;
          end
        end
      end else if (start) begin
        if (image_width != 0 && image_height != 0) begin
          m_w = int'(image_width);
          m_h = int'(image_height);
          e   = int'(no_of_extra_cores) + 1;
          m_n = (e > MAXC) ? MAXC : e;
          m_k = 0;
          m_act = 1;
        end else begin
          m_fd = 1;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("core_valid", int'(core_valid), m_act ? (1 << (m_k % m_n)) : 0);
      chk("pix_x", int'(pix_x), m_act ? (m_k % m_w) : 0);
      chk("pix_y", int'(pix_y), m_act ? (m_k / m_w) : 0);
      chk("sof", int'(sof), int'(m_act && m_k == 0));
      chk("eol", int'(eol), int'(m_act && (m_k % m_w) == m_w - 1));
      chk("busy", int'(busy), int'(m_act || m_done));
      chk("frame_done", int'(frame_done), int'(m_fd));
    end
  end

  typedef struct {int cv; int x; int y; int sof; int eol; int cyc;} xfer_t;
  xfer_t xlog[$];

  always @(posedge aclk) begin
    cyc++;
    if (aresetn && (core_valid & core_ready) != 0)
      xlog.push_back('{int'(core_valid), int'(pix_x), int'(pix_y), int'(sof), int'(eol), cyc});
  end

  task automatic run_start(input int w, input int h, input int e);
    image_width       = CW'(w);
    image_height      = CW'(h);
    no_of_extra_cores = 3'(e);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!frame_done && n < limit) begin
      @(negedge aclk);
      n++;
    end
    chk("frame_done_timeout", int'(frame_done), 1);
    @(negedge aclk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_core_valid"}, int'(core_valid), 0);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_sof"}, int'(sof), 0);
    chk({tag, "_eol"}, int'(eol), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cv[8] = '{1, 2, 1, 2, 1, 2, 1, 2};
    int exp_x[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_y[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    aresetn = 1'b0; start = 1'b0; image_width = '0; image_height = '0;
    no_of_extra_cores = '0; core_ready = '0;
    repeat (2) @(negedge aclk);
    chk_zero_outputs("reset");
    aresetn = 1'b1;
    @(negedge aclk);
    cmp_en = 1'b1;

    // 4x2 frame, two cores always ready; dims changed mid-frame must not matter
    core_ready = 2'b11;
    xlog.delete();
    run_start(4, 2, 1);
    image_width = CW'(7); image_height = CW'(9); no_of_extra_cores = 3'd0;
    wait_done(40);
    chk("f1_count", xlog.size(), 8);
    if (xlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("f1_core", xlog[i].cv, exp_cv[i]);
        chk("f1_x", xlog[i].x, exp_x[i]);
        chk("f1_y", xlog[i].y, exp_y[i]);
        chk("f1_sof", xlog[i].sof, int'(i == 0));
        chk("f1_eol", xlog[i].eol, int'(i == 3 || i == 7));
      end
      chk("f1_consecutive", xlog[7].cyc - xlog[0].cyc, 7);
    end

    // Backpressure on core0 while (2,0) is offered; core1 ready must not leak
    core_ready = 2'b11;
    xlog.delete();
    run_start(4, 2, 1);
    @(negedge aclk);
    core_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("bp_core_valid", int'(core_valid), 1);
      chk("bp_pix_x", int'(pix_x), 2);
      chk("bp_pix_y", int'(pix_y), 0);
    end
    chk("bp_count_held", xlog.size(), 2);
    core_ready = 2'b11;
    wait_done(40);
    chk("bp_count", xlog.size(), 8);

    // Zero width: immediate frame_done, never busy
    run_start(0, 5, 0);
    chk("zw_frame_done", int'(frame_done), 1);
    chk("zw_busy", int'(busy), 0);
    chk("zw_core_valid", int'(core_valid), 0);
    @(negedge aclk);
    chk("zw_frame_done_off", int'(frame_done), 0);

    // Core count clamped to MAX_CORES
    core_ready = 2'b11;
    xlog.delete();
    run_start(3, 1, 5);
    wait_done(20);
    chk("cl_count", xlog.size(), 3);
    if (xlog.size() == 3) begin
      chk("cl_core0", xlog[0].cv, 1);
      chk("cl_core1", xlog[1].cv, 2);
      chk("cl_core2", xlog[2].cv, 1);
      chk("cl_x2", xlog[2].x, 2);
    end

    // 1x1 frame with a start pulse during dispatch
    core_ready = 2'b00;
    xlog.delete();
    run_start(1, 1, 0);
    chk("one_core_valid", int'(core_valid), 1);
    chk("one_sof", int'(sof), 1);
    chk("one_eol", int'(eol), 1);
    run_start(4, 4, 1);
    chk("one_hold_valid", int'(core_valid), 1);
    chk("one_hold_busy", int'(busy), 1);
    core_ready = 2'b01;
    wait_done(20);
    chk("one_count", xlog.size(), 1);
    @(negedge aclk);
    chk("one_idle_busy", int'(busy), 0);

    // Asynchronous reset mid-frame
    core_ready = 2'b11;
    run_start(4, 2, 1);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 chk_zero_outputs("arst");
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("arst_no_done", int'(frame_done), 0);
      chk("arst_idle", int'(busy), 0);
    end
    core_ready = 2'b00;
    run_start(4, 2, 1);
    chk("rs_core_valid", int'(core_valid), 1);
    chk("rs_pix_x", int'(pix_x), 0);
    chk("rs_pix_y", int'(pix_y), 0);
    chk("rs_sof", int'(sof), 1);
    core_ready = 2'b11;
    wait_done(40);

    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 SHALL have parameter MAX_CORES, default 2, number of core ports (1..8).
REQ-002 SHALL have parameter COORD_W, default 13, coordinate/dimension width.
REQ-003 SHALL have port aclk  input  1  sole clock, rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port image_width  input  COORD_W  pixels per line, latched on accepted start.
REQ-007 SHALL have port image_height  input  COORD_W  lines per frame, latched on accepted start.
REQ-008 SHALL have port no_of_extra_cores  input  3  active cores minus one, latched on accepted start.
REQ-009 SHALL have port core_ready  input  MAX_CORES  per-core accept-pixel.
REQ-010 SHALL have port core_valid  output  MAX_CORES  per-core pixel-offered, at most one bit high.
REQ-011 SHALL have port pix_x, pix_y  output  COORD_W each  coordinate of offered pixel, shared by all cores.
REQ-012 SHALL have port sof, eol  output  1 each  offered pixel is first of frame / last of line.
REQ-013 SHALL have ports busy  output  1 (state != IDLE) and frame_done  output  1 (one-cycle pulse).

Function
REQ-014 SHALL implement states IDLE, DISPATCH, DONE.
REQ-015 IDLE: start high with width != 0 and height != 0 SHALL latch dimensions, set x=0, y=0, core_idx=0, go DISPATCH next cycle.
REQ-016 IDLE: start high with width == 0 or height == 0 SHALL pulse frame_done next cycle, stay IDLE, assert no core_valid.
REQ-017 Active core count N SHALL be min(no_of_extra_cores+1, MAX_CORES); clamping applied at latch time.
REQ-018 DISPATCH: core_valid[core_idx] SHALL be 1, all other bits 0; pix_x/pix_y SHALL equal the current x/y.
REQ-019 sof SHALL be 1 when x==0 and y==0; eol SHALL be 1 when x==width-1; both 0 outside DISPATCH.
REQ-020 Transfer SHALL occur on a cycle with core_valid[core_idx] and core_ready[core_idx] both 1; core_ready of non-selected cores SHALL be ignored.
REQ-021 Without transfer, core_valid, pix_x, pix_y, sof, eol SHALL hold stable (no retraction).
REQ-022 On transfer: x SHALL increment; at x==width-1, x SHALL wrap to 0 and y SHALL increment.
REQ-023 On transfer: core_idx SHALL increment, wrapping to 0 after N-1, so raster pixel k goes to core k mod N.
REQ-024 Transfer of pixel (width-1, height-1) SHALL move to DONE; DONE SHALL pulse frame_done one cycle then return to IDLE.
REQ-025 Sustained readiness SHALL give one transfer per cycle; first core_valid SHALL rise the cycle after accepted start.
REQ-026 start while busy SHALL be ignored; inputs image_width/height/no_of_extra_cores SHALL not affect a frame in progress.
REQ-027 Outputs SHALL be driven only from registers (no combinational path from core_ready or start to any output).
REQ-028 Arithmetic SHALL be unsigned COORD_W; width*height product SHALL not be computed (compare x,y against dimension-1).

Reset
REQ-029 aresetn low SHALL immediately force state IDLE, x=y=0, core_idx=0, latched dims 0.
REQ-030 During and after reset: core_valid=0, pix_x=pix_y=0, sof=eol=0, busy=0, frame_done=0.
REQ-031 Reset mid-frame SHALL abort the frame without frame_done; next frame requires a new start.

Verification
REQ-032 width=4, height=2, extra=1, core_ready=2'b11: 8 transfers in 8 consecutive cycles; core0 gets (0,0),(2,0),(0,1),(2,1); core1 gets (1,0),(3,0),(1,1),(3,1); sof only on (0,0); eol on (3,0),(3,1); frame_done one cycle after last transfer.
REQ-033 Backpressure: core_ready[0]=0 for 5 cycles while offering (2,0) -> core_valid[0]=1, pix_x=2, pix_y=0 stable 5 cycles; core_ready[1]=1 meanwhile causes no transfer.
REQ-034 start with width=0, height=5 -> frame_done pulse next cycle, core_valid stays 0, busy stays 0.
REQ-035 MAX_CORES=2, extra=5, width=3, height=1 -> N=2: (0,0)->core0, (1,0)->core1, (2,0)->core0.
REQ-036 width=1, height=1 -> single offer to core0 with sof=1, eol=1; start pulsed during DISPATCH ignored.
REQ-037 aresetn asserted asynchronously mid-frame (between clock edges) -> all outputs 0 before next edge; no frame_done; new start restarts at (0,0), core0.
